// File: rtl/adder_tree_sched_if.sv
// Handshake bundle for the time-shared reduction engine: serial operand
// streams in from NUM_REQ producers, one tagged sum out to the consumer.
interface adder_tree_sched_if #(
   parameter int ADDER_WIDTH = 23,
   parameter int NUM_REQ     = 4,
   parameter int LOG_OPS     = 3,
   parameter int ID_W        = 2
);
   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ*ADDER_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]             req_ready;
   logic                           out_valid;
   logic                           out_ready;
   logic [ADDER_WIDTH+LOG_OPS-1:0] out_sum;
   logic [ID_W-1:0]                out_id;

   modport master (
      output req_valid,
      output req_data,
      output out_ready,
      input  req_ready,
      input  out_valid,
      input  out_sum,
      input  out_id
   );

   modport slave (
      input  req_valid,
      input  req_data,
      input  out_ready,
      output req_ready,
      output out_valid,
      output out_sum,
      output out_id
   );
endinterface

// File: rtl/adder_tree_sched.sv
// Round-robin scheduler sharing one registered adder and accumulator across
// NUM_REQ requesters; each job sums NUM_OPS operands at full precision.
module adder_tree_sched #(
   parameter int ADDER_WIDTH = 23,
   parameter int NUM_REQ     = 4,
   parameter int NUM_OPS     = 8,
   parameter int LOG_OPS     = 3,
   parameter int ID_W        = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   adder_tree_sched_if.slave    bus,
   output logic                 busy
);
   localparam int SUM_W = ADDER_WIDTH + LOG_OPS;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [ID_W-1:0]    grant_q, grant_d;
   logic [ID_W-1:0]    last_grant_q, last_grant_d;
   logic [ID_W-1:0]    out_id_q, out_id_d;
   logic [SUM_W-1:0]   acc_q, acc_d;
   logic [SUM_W-1:0]   out_sum_q, out_sum_d;
   logic [LOG_OPS-1:0] cnt_q, cnt_d;

   logic [ADDER_WIDTH-1:0] operand_arr [NUM_REQ];
   logic [ADDER_WIDTH-1:0] operand;
   logic [SUM_W-1:0]       acc_sum;
   logic [NUM_REQ-1:0]     ready_vec;
   logic                   beat;
   logic                   last_beat;
   logic                   found;
   logic [ID_W-1:0]        winner;
   logic [ID_W-1:0]        cand;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign operand_arr[g] = bus.req_data[g*ADDER_WIDTH +: ADDER_WIDTH];
   end

   assign operand   = operand_arr[grant_q];
   assign beat      = (state_q == ACCUM) && bus.req_valid[grant_q];
   assign last_beat = beat && (cnt_q == LOG_OPS'(NUM_OPS - 1));
   assign acc_sum   = acc_q + {{LOG_OPS{1'b0}}, operand};

   // Cyclic search starting just after the previous owner, so a requester
   // that keeps asking is reached within NUM_REQ jobs.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = ID_W'((int'(last_grant_q) + i) % NUM_REQ);
         if (!found && bus.req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      out_sum_d    = out_sum_q;
      out_id_d     = out_id_q;
      ready_vec    = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = winner;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            ready_vec[grant_q] = 1'b1;
            if (beat) begin
               acc_d = acc_sum;
               cnt_d = cnt_q + LOG_OPS'(1);
               if (last_beat) begin
                  out_sum_d    = acc_sum;
                  out_id_d     = grant_q;
                  last_grant_d = grant_q;
                  state_d      = DONE;
               end
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= ID_W'(NUM_REQ - 1);
         acc_q        <= '0;
         cnt_q        <= '0;
         out_sum_q    <= '0;
         out_id_q     <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         out_sum_q    <= out_sum_d;
         out_id_q     <= out_id_d;
      end
   end

   assign bus.req_ready = ready_vec;
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_sum   = out_sum_q;
   assign bus.out_id    = out_id_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_adder_tree_sched.sv
// Directed bench for adder_tree_sched: cycle-stepped producer model plus a
// small round-robin predictor; all results compared against hand-computed sums.
module tb_adder_tree_sched;
   localparam int AW = 23;
   localparam int NR = 4;
   localparam int NO = 8;
   localparam int LO = 3;
   localparam int IW = 2;

   logic clk;
   logic rst;
   logic busy;

   adder_tree_sched_if #(.ADDER_WIDTH(AW), .NUM_REQ(NR), .LOG_OPS(LO), .ID_W(IW)) bus ();

   adder_tree_sched #(
      .ADDER_WIDTH(AW),
      .NUM_REQ(NR),
      .NUM_OPS(NO),
      .LOG_OPS(LO),
      .ID_W(IW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checkCount;
   int          failCount;
   int          cycle;
   logic [AW-1:0] opVal [NR][NO];
   int          beatIdx [NR];
   int          jobsLeft [NR];
   int          stallAfter [NR];
   int          stallLen [NR];
   int          stallDone [NR];
   int          readyCycles [NR];
   int          firstReady [NR];
   int          lastReady [NR];
   int          lastBeatCycle;
   int          riseCycle;
   int          expGrant;
   int          lastG;
   logic        prevOutValid;
   logic        outReadyNext;
   int          resId [$];
   logic [63:0] resSum [$];
   int          resRise [$];

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic clearProducers();
      for (int r = 0; r < NR; r++) begin
         beatIdx[r]     = NO;
         jobsLeft[r]    = 0;
         stallAfter[r]  = -1;
         stallLen[r]    = 0;
         stallDone[r]   = 0;
         readyCycles[r] = 0;
         firstReady[r]  = -1;
         lastReady[r]   = -1;
      end
      resId.delete();
      resSum.delete();
      resRise.delete();
   endtask

   task automatic resetDut();
      @(negedge clk);
      rst = 1'b1;
      clearProducers();
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.out_ready = outReadyNext;
      @(negedge clk);
      rst          = 1'b0;
      lastG        = NR - 1;
      expGrant     = -1;
      prevOutValid = 1'b0;
      #1;
   endtask

   task automatic startJob(input int r, input int jobs);
      beatIdx[r]   = 0;
      jobsLeft[r]  = jobs;
      stallDone[r] = 0;
   endtask

   // One clock of producer/consumer behaviour: drive at negedge, observe, and
   // book-keep the beat or result that the coming posedge will commit.
   task automatic applyStimulus();
      logic [NR*AW-1:0] dataVec;
      logic [NR-1:0]    validVec;
      logic             picked;
      int               c;
      @(negedge clk);
      cycle++;
      dataVec  = '0;
      validVec = '0;
      for (int r = 0; r < NR; r++) begin
         if (jobsLeft[r] > 0 && beatIdx[r] < NO) begin
            if (beatIdx[r] == stallAfter[r] && stallDone[r] < stallLen[r]) begin
               stallDone[r]++;
            end else begin
               validVec[r] = 1'b1;
            end
            dataVec[r*AW +: AW] = opVal[r][beatIdx[r]];
         end
      end
      bus.req_valid = validVec;
      bus.req_data  = dataVec;
      bus.out_ready = outReadyNext;
      #1;
      if (!busy && validVec != '0) begin
         picked = 1'b0;
         for (int i = 1; i <= NR; i++) begin
            c = (lastG + i) % NR;
            if (!picked && validVec[c]) begin
               picked   = 1'b1;
               expGrant = c;
            end
         end
      end
      if (bus.req_ready != '0) begin
         checkOutput("ready_grant", 64'(bus.req_ready), 64'(1) << expGrant);
      end
      for (int r = 0; r < NR; r++) begin
         if (bus.req_ready[r]) begin
            readyCycles[r]++;
            if (firstReady[r] < 0) firstReady[r] = cycle;
            lastReady[r] = cycle;
         end
         if (validVec[r] && bus.req_ready[r]) begin
            beatIdx[r]++;
            lastBeatCycle = cycle;
            if (beatIdx[r] == NO) begin
               jobsLeft[r]--;
               if (jobsLeft[r] > 0) begin
                  beatIdx[r]   = 0;
                  stallDone[r] = 0;
               end
            end
         end
      end
      if (bus.out_valid && !prevOutValid) riseCycle = cycle;
      if (bus.out_valid && bus.out_ready) begin
         resId.push_back(int'(bus.out_id));
         resSum.push_back(64'(bus.out_sum));
         resRise.push_back(riseCycle);
         lastG = expGrant;
      end
      prevOutValid = bus.out_valid;
   endtask

   task automatic runUntil(input int n, input int budget);
      int spent;
      spent = 0;
      while (resId.size() < n && spent < budget) begin
         applyStimulus();
         spent++;
      end
      if (resId.size() < n) begin
         checkOutput("result_timeout", 64'(resId.size()), 64'(n));
         for (int k = resId.size(); k < n; k++) begin
            resId.push_back(-1);
            resSum.push_back('1);
            resRise.push_back(-1);
         end
      end
   endtask

   initial begin
      int start;
      int waitCnt;
      checkCount    = 0;
      failCount     = 0;
      cycle         = 0;
      lastBeatCycle = -1;
      riseCycle     = -1;
      rst           = 1'b1;
      outReadyNext  = 1'b1;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.out_ready = 1'b0;
      clearProducers();
      resetDut();

      checkOutput("rst_ready", 64'(bus.req_ready), 64'd0);
      checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("rst_out_sum", 64'(bus.out_sum), 64'd0);
      checkOutput("rst_out_id", 64'(bus.out_id), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);

      // Single job from requester 2, operands 1..8
      for (int k = 0; k < NO; k++) opVal[2][k] = AW'(k + 1);
      startJob(2, 1);
      runUntil(1, 40);
      checkOutput("t1_id", 64'(resId[0]), 64'd2);
      checkOutput("t1_sum", resSum[0], 64'd36);
      checkOutput("t1_ready_cycles", 64'(readyCycles[2]), 64'd8);
      checkOutput("t1_ready_span", 64'(lastReady[2] - firstReady[2]), 64'd7);
      checkOutput("t1_latency", 64'(resRise[0]), 64'(lastBeatCycle + 1));
      applyStimulus();
      checkOutput("t1_valid_drop", 64'(bus.out_valid), 64'd0);
      checkOutput("t1_idle", 64'(busy), 64'd0);

      // Full-scale operands must not truncate
      resetDut();
      for (int k = 0; k < NO; k++) opVal[0][k] = 23'h7FFFFF;
      startJob(0, 1);
      runUntil(1, 40);
      checkOutput("t2_id", 64'(resId[0]), 64'd0);
      checkOutput("t2_sum", resSum[0], 64'h3FFFFF8);

      // Four persistent requesters are served in rotation
      resetDut();
      for (int r = 0; r < NR; r++) begin
         for (int k = 0; k < NO; k++) opVal[r][k] = AW'(r + 1);
         startJob(r, 2);
      end
      runUntil(5, 200);
      checkOutput("t3_id0", 64'(resId[0]), 64'd0);
      checkOutput("t3_id1", 64'(resId[1]), 64'd1);
      checkOutput("t3_id2", 64'(resId[2]), 64'd2);
      checkOutput("t3_id3", 64'(resId[3]), 64'd3);
      checkOutput("t3_id4", 64'(resId[4]), 64'd0);
      checkOutput("t3_sum0", resSum[0], 64'd8);
      checkOutput("t3_sum1", resSum[1], 64'd16);
      checkOutput("t3_sum2", resSum[2], 64'd24);
      checkOutput("t3_sum3", resSum[3], 64'd32);
      checkOutput("t3_sum4", resSum[4], 64'd8);

      // Producer stall of 5 cycles after beat 3
      resetDut();
      for (int k = 0; k < NO; k++) opVal[1][k] = AW'(10 * (k + 1));
      stallAfter[1] = 3;
      stallLen[1]   = 5;
      startJob(1, 1);
      start = cycle + 1;
      runUntil(1, 60);
      checkOutput("t4a_id", 64'(resId[0]), 64'd1);
      checkOutput("t4a_sum", resSum[0], 64'd360);
      checkOutput("t4a_rise", 64'(resRise[0]), 64'(start + 14));

      // Consumer backpressure: result must hold for 10 cycles
      resetDut();
      for (int k = 0; k < NO; k++) opVal[2][k] = AW'(3 * k + 1);
      outReadyNext = 1'b0;
      startJob(2, 1);
      waitCnt = 0;
      applyStimulus();
      while (!bus.out_valid && waitCnt < 30) begin
         applyStimulus();
         waitCnt++;
      end
      checkOutput("t4b_valid_seen", 64'(bus.out_valid), 64'd1);
      for (int h = 0; h < 10; h++) begin
         applyStimulus();
         checkOutput("t4b_hold_valid", 64'(bus.out_valid), 64'd1);
         checkOutput("t4b_hold_sum", 64'(bus.out_sum), 64'd92);
         checkOutput("t4b_hold_id", 64'(bus.out_id), 64'd2);
         checkOutput("t4b_hold_busy", 64'(busy), 64'd1);
      end
      outReadyNext = 1'b1;
      applyStimulus();
      checkOutput("t4b_accepted", 64'(resId.size()), 64'd1);
      checkOutput("t4b_accept_busy", 64'(busy), 64'd1);
      applyStimulus();
      checkOutput("t4b_idle_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("t4b_idle_busy", 64'(busy), 64'd0);

      // Reset after 4 beats of requester 3 aborts the job
      clearProducers();
      for (int k = 0; k < NO; k++) opVal[3][k] = AW'(9);
      startJob(3, 1);
      waitCnt = 0;
      while (beatIdx[3] < 4 && waitCnt < 30) begin
         applyStimulus();
         waitCnt++;
      end
      checkOutput("t5_beats_before_rst", 64'(beatIdx[3]), 64'd4);
      resetDut();
      checkOutput("t5_ready", 64'(bus.req_ready), 64'd0);
      checkOutput("t5_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("t5_out_sum", 64'(bus.out_sum), 64'd0);
      checkOutput("t5_out_id", 64'(bus.out_id), 64'd0);
      checkOutput("t5_busy", 64'(busy), 64'd0);
      for (int w = 0; w < 12; w++) applyStimulus();
      checkOutput("t5_no_result", 64'(resId.size()), 64'd0);
      for (int k = 0; k < NO; k++) opVal[0][k] = AW'(5);
      startJob(0, 1);
      runUntil(1, 40);
      checkOutput("t5_id", 64'(resId[0]), 64'd0);
      checkOutput("t5_sum", resSum[0], 64'd40);

      // Sparse requests: only 3, then only 1
      clearProducers();
      for (int k = 0; k < NO; k++) opVal[3][k] = AW'(2);
      startJob(3, 1);
      runUntil(1, 40);
      checkOutput("t6_id_first", 64'(resId[0]), 64'd3);
      checkOutput("t6_sum_first", resSum[0], 64'd16);
      clearProducers();
      for (int k = 0; k < NO; k++) opVal[1][k] = AW'(100);
      startJob(1, 1);
      runUntil(1, 40);
      checkOutput("t6_id_second", 64'(resId[0]), 64'd1);
      checkOutput("t6_sum_second", resSum[0], 64'd800);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
